conv_line_ctrl: RTL and testbench

CONV_LINE_CTRL -- requirements
Module: conv_line_ctrl

---
 rtl/conv_line_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_conv_line_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_ctrl.sv
// conv_line_ctrl: line controller for a TAPS-long PE chain.
// Loads TAPS weights, streams one line of pixels into the chain, tracks which
// chain outputs are valid results with a tag pipe that advances in lockstep
// with the datapath, and hands the saturated chain result out on a
// valid/ready port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. Ready never depends on valid; valid, once raised on the result
// port, holds with stable data until a transfer takes it.
module conv_line_ctrl #(
    parameter int I_X   = 8,
    parameter int I_W   = 8,
    parameter int O_SAT = 16,
    parameter int TAPS  = 5,
    parameter int LAT   = 5,
    parameter int LEN_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [LEN_W-1:0]      i_len,
    input  logic                  i_w_valid,
    output logic                  o_w_ready,
    input  logic [I_W-1:0]        i_w,
    input  logic                  i_x_valid,
    output logic                  o_x_ready,
    input  logic [I_X-1:0]        i_x,
    output logic                  o_dp_en,
    output logic [I_X-1:0]        o_dp_x,
    output logic [TAPS*I_W-1:0]   o_dp_w,
    input  logic [O_SAT-1:0]      i_dp_psum,
    output logic                  o_y_valid,
    input  logic                  i_y_ready,
    output logic [O_SAT-1:0]      o_y,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int WC_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [WC_W-1:0]  LAST_TAP  = WC_W'(TAPS - 1);
    localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(TAPS);
    localparam logic [LEN_W-1:0] TAG_START = LEN_W'(TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [LEN_W-1:0] r_len;
    logic [WC_W-1:0]  r_w_cnt;
    logic [LEN_W-1:0] r_x_cnt;
    logic [LAT-1:0]   r_tag;
    logic [I_W-1:0]   r_w [TAPS];
    logic             r_y_valid;
    logic [O_SAT-1:0] r_y;
    logic             r_err;

    logic             w_stall;
    logic             w_w_ready;
    logic             w_x_ready;
    logic             w_w_fire;
    logic             w_x_fire;
    logic             w_dp_en;
    logic [I_X-1:0]   w_dp_x;
    logic             w_tag_in;
    logic             w_busy;
    logic             w_done;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_capture;
    logic [TAPS*I_W-1:0] w_dp_w;

    // A held result that the consumer refuses freezes the whole datapath.
    assign w_stall   = r_y_valid && !i_y_ready;
    // The tail tag marks the chain output belonging to a full window.
    assign w_capture = w_dp_en && r_tag[LAT-1];

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-state handshake / datapath controls.
    always_comb begin
        w_next_state = r_state;
        w_w_ready    = 1'b0;
        w_x_ready    = 1'b0;
        w_w_fire     = 1'b0;
        w_x_fire     = 1'b0;
        w_dp_en      = 1'b0;
        w_dp_x       = '0;
        w_tag_in     = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_start_ok   = 1'b0;
        w_start_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_start) begin
                    if (i_len >= MIN_LEN) begin
                        w_start_ok   = 1'b1;
                        w_next_state = S_LOAD_W;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            S_LOAD_W: begin
                w_w_ready = 1'b1;
                w_w_fire  = i_w_valid;
                if (w_w_fire && (r_w_cnt == LAST_TAP)) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_x_ready = !w_stall;
                w_x_fire  = i_x_valid && !w_stall;
                if (w_x_fire) begin
                    w_dp_en  = 1'b1;
                    w_dp_x   = i_x;
                    w_tag_in = (r_x_cnt >= TAG_START);
                    if (r_x_cnt == (r_len - LEN_W'(1))) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Push zeros through the chain until every tagged result is out.
                w_dp_en = !w_stall;
                if ((r_tag == '0) && !r_y_valid) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Line length, counters, weight registers and the tag pipe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_len   <= '0;
            r_w_cnt <= '0;
            r_x_cnt <= '0;
            r_tag   <= '0;
            for (int k = 0; k < TAPS; k++) begin
                r_w[k] <= '0;
            end
        end else begin
            if (w_start_ok) begin
                r_len   <= i_len;
                r_w_cnt <= '0;
                r_x_cnt <= '0;
                r_tag   <= '0;
            end
            if (w_w_fire) begin
                r_w[r_w_cnt] <= i_w;
                r_w_cnt      <= r_w_cnt + 1'b1;
            end
            if (w_x_fire) begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end
            if (w_dp_en) begin
                r_tag <= {r_tag[LAT-2:0], w_tag_in};
            end
        end
    end

    // Result register and the bad-length pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_y_valid <= 1'b0;
            r_y       <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_capture) begin
                r_y       <= i_dp_psum;
                r_y_valid <= 1'b1;
            end else if (i_y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    // Pack the weight registers onto the chain bus, tap k at [k*I_W +: I_W].
    always_comb begin
        w_dp_w = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_dp_w[k*I_W +: I_W] = r_w[k];
        end
    end

    assign o_w_ready = w_w_ready;
    assign o_x_ready = w_x_ready;
    assign o_dp_en   = w_dp_en;
    assign o_dp_x    = w_dp_x;
    assign o_dp_w    = w_dp_w;
    assign o_y_valid = r_y_valid;
    assign o_y       = r_y;
    assign o_busy    = w_busy;
    assign o_done    = w_done;
    assign o_err     = r_err;

endmodule

// File: tb/tb_conv_line_ctrl.sv
// tb_conv_line_ctrl: drives conv_line_ctrl with a behavioural 5-tap PE chain
// and checks every result against a line-level convolution reference.
module tb_conv_line_ctrl;

    localparam int I_X   = 8;
    localparam int I_W   = 8;
    localparam int O_SAT = 16;
    localparam int TAPS  = 5;
    localparam int LAT   = 5;
    localparam int LEN_W = 8;

    logic                clk;
    logic                i_rst_n;
    logic                i_start;
    logic [LEN_W-1:0]    i_len;
    logic                i_w_valid;
    logic                o_w_ready;
    logic [I_W-1:0]      i_w;
    logic                i_x_valid;
    logic                o_x_ready;
    logic [I_X-1:0]      i_x;
    logic                o_dp_en;
    logic [I_X-1:0]      o_dp_x;
    logic [TAPS*I_W-1:0] o_dp_w;
    logic [O_SAT-1:0]    i_dp_psum;
    logic                o_y_valid;
    logic                i_y_ready;
    logic [O_SAT-1:0]    o_y;
    logic                o_busy;
    logic                o_done;
    logic                o_err;

    conv_line_ctrl #(
        .I_X(I_X), .I_W(I_W), .O_SAT(O_SAT), .TAPS(TAPS), .LAT(LAT), .LEN_W(LEN_W)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len),
        .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w(i_w),
        .i_x_valid(i_x_valid), .o_x_ready(o_x_ready), .i_x(i_x),
        .o_dp_en(o_dp_en), .o_dp_x(o_dp_x), .o_dp_w(o_dp_w), .i_dp_psum(i_dp_psum),
        .o_y_valid(o_y_valid), .i_y_ready(i_y_ready), .o_y(o_y),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_vec  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    bit rst_check_en = 1'b0;
    bit gaps = 1'b0;
    int y_mode = 0;
    int stall_left = 0;
    bit stall_used = 1'b0;

    int line_x [256];
    int line_w [TAPS];

    logic [O_SAT-1:0] exp_q [$];
    logic [O_SAT-1:0] got_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [O_SAT-1:0] sat(input longint v);
        longint mx;
        mx = (longint'(1) << O_SAT) - 1;
        return (v > mx) ? O_SAT'(mx) : O_SAT'(v);
    endfunction

    // Result for the window ending at pixel p: tap k weights pixel p-k.
    function automatic logic [O_SAT-1:0] ref_y(input int p);
        longint s;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(line_w[k]) * longint'(line_x[p-k]);
        return sat(s);
    endfunction

    function automatic logic [O_SAT-1:0] got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : 16'hDEAD;
    endfunction

    // ---------------- behavioural PE chain ----------------
    logic [I_X-1:0]   dp_win  [TAPS-1];
    logic [O_SAT-1:0] dp_pipe [LAT];
    assign i_dp_psum = dp_pipe[LAT-1];

    always @(posedge clk) begin
        longint s;
        if (!i_rst_n) begin
            for (int k = 0; k < TAPS-1; k++) dp_win[k] <= '0;
            for (int k = 0; k < LAT; k++) dp_pipe[k] <= '0;
        end else if (o_dp_en) begin
            s = longint'(o_dp_w[0 +: I_W]) * longint'(o_dp_x);
            for (int k = 1; k < TAPS; k++)
                s += longint'(o_dp_w[k*I_W +: I_W]) * longint'(dp_win[k-1]);
            dp_win[0] <= o_dp_x;
            for (int k = 1; k < TAPS-1; k++) dp_win[k] <= dp_win[k-1];
            dp_pipe[0] <= sat(s);
            for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
        end
    end

    // ---------------- result-ready driver ----------------
    initial begin
        i_y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (y_mode)
                1: i_y_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (stall_left > 0) begin
                        i_y_ready = 1'b0;
                        stall_left--;
                    end else if (!stall_used && o_y_valid) begin
                        stall_used = 1'b1;
                        stall_left = 9;
                        i_y_ready  = 1'b0;
                    end else begin
                        i_y_ready = 1'b1;
                    end
                end
                default: i_y_ready = 1'b1;
            endcase
        end
    end

    // ---------------- compare process ----------------
    bit               prev_hold = 1'b0;
    logic [O_SAT-1:0] prev_y;

    always @(negedge clk) begin
        if (!i_rst_n) begin
            prev_hold = 1'b0;
            if (rst_check_en) begin
                chk("rst_busy", o_busy, 0);       chk("rst_done", o_done, 0);
                chk("rst_err", o_err, 0);         chk("rst_y_valid", o_y_valid, 0);
                chk("rst_dp_en", o_dp_en, 0);     chk("rst_w_ready", o_w_ready, 0);
                chk("rst_x_ready", o_x_ready, 0); chk("rst_y", o_y, 0);
                chk("rst_dp_x", o_dp_x, 0);       chk("rst_dp_w", o_dp_w, 0);
            end
        end else begin
            if (prev_hold) begin
                chk("hold_y_valid", o_y_valid, 1);
                chk("hold_y", o_y, prev_y);
            end
            if (o_y_valid && i_y_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", o_y_valid, 0);
                end else begin
                    chk("y", o_y, exp_q.pop_front());
                end
                got_q.push_back(o_y);
            end
            if (o_y_valid && !i_y_ready) begin
                chk("stall_x_ready", o_x_ready, 0);
                chk("stall_dp_en", o_dp_en, 0);
                prev_hold = 1'b1;
                prev_y    = o_y;
            end else begin
                prev_hold = 1'b0;
            end
            if (o_done) begin
                chk("done_pending_results", exp_q.size(), 0);
                done_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        i_rst_n = 1'b0;
        tick();
        rst_check_en = 1'b1;
        repeat (n - 1) tick();
        rst_check_en = 1'b0;
        i_rst_n = 1'b1;
    endtask

    task automatic start_line(input int len);
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        tick();
        i_start = 1'b0;
    endtask

    task automatic load_w();
        int  idx = 0;
        int  guard = 0;
        bit  fire;
        while (idx < TAPS && guard < 1000) begin
            i_w_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_w       = I_W'(line_w[idx]);
            @(negedge clk);
            fire = i_w_valid && o_w_ready;
            tick();
            if (fire) idx++;
            guard++;
        end
        i_w_valid = 1'b0;
        chk("weights_loaded", idx, TAPS);
    endtask

    task automatic send_x(input int count, input int start_at);
        int  idx = 0;
        int  guard = 0;
        bit  fire;
        bit  pulsed = 1'b0;
        while (idx < count && guard < 5000) begin
            i_x_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_x       = I_X'(line_x[idx]);
            if (idx == start_at && !pulsed) begin
                i_start = 1'b1;
                i_len   = LEN_W'(6);
                pulsed  = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            fire = i_x_valid && o_x_ready;
            tick();
            if (fire) idx++;
            guard++;
        end
        i_x_valid = 1'b0;
        i_start   = 1'b0;
        chk("pixels_sent", idx, count);
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int guard = 0;
        while (done_cnt == d0 && guard < 5000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("busy_after_done", o_busy, 0);
        #1;
    endtask

    task automatic run_line(input int len, input int ymode, input int start_at);
        logic [TAPS*I_W-1:0] pw;
        pw = '0;
        for (int k = 0; k < TAPS; k++) pw[k*I_W +: I_W] = I_W'(line_w[k]);
        for (int p = TAPS-1; p < len; p++) exp_q.push_back(ref_y(p));
        got_q.delete();
        y_mode = ymode;
        stall_used = 1'b0;
        start_line(len);
        load_w();
        send_x(len, start_at);
        wait_done();
        chk("result_count", got_q.size(), len - TAPS + 1);
        chk("weights_held", o_dp_w, pw);
    endtask

    task automatic check_err_start(input int len);
        int errc = 0;
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_err) errc++;
            chk("err_busy", o_busy, 0);
            tick();
            i_start = 1'b0;
        end
        chk("err_pulse_count", errc, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        i_rst_n = 1'b0; i_start = 1'b0; i_len = '0;
        i_w_valid = 1'b0; i_w = '0; i_x_valid = 1'b0; i_x = '0;
        exp_q.delete();
        do_reset(3);
        tick();

        // One window: weights 1..5 over all-ones pixels.
        for (int k = 0; k < TAPS; k++) line_w[k] = k + 1;
        for (int i = 0; i < 5; i++) line_x[i] = 1;
        run_line(5, 0, -1);
        chk("pin_req022_y0", got_at(0), 15);

        // Unit weights over a ramp.
        for (int k = 0; k < TAPS; k++) line_w[k] = 1;
        for (int i = 0; i < 8; i++) line_x[i] = i + 1;
        run_line(8, 0, -1);
        chk("pin_ramp_y0", got_at(0), 15); chk("pin_ramp_y1", got_at(1), 20);
        chk("pin_ramp_y2", got_at(2), 25); chk("pin_ramp_y3", got_at(3), 30);

        // Same ramp with a 10-cycle consumer stall after the first result.
        run_line(8, 2, -1);
        chk("pin_stall_y0", got_at(0), 15); chk("pin_stall_y1", got_at(1), 20);
        chk("pin_stall_y2", got_at(2), 25); chk("pin_stall_y3", got_at(3), 30);

        // Too-short lines are rejected without leaving IDLE.
        check_err_start(3);
        check_err_start(TAPS - 1);
        check_err_start(0);

        // Random line with a start pulse during RUN that must be ignored.
        gaps = 1'b1;
        for (int k = 0; k < TAPS; k++) line_w[k] = $urandom_range(0, 255);
        for (int i = 0; i < 10; i++) line_x[i] = $urandom_range(0, 255);
        run_line(10, 1, 2);

        // Full-length line with random gaps on every stream.
        for (int k = 0; k < TAPS; k++) line_w[k] = $urandom_range(0, 255);
        for (int i = 0; i < 255; i++) line_x[i] = $urandom_range(0, 255);
        run_line(255, 1, -1);
        chk("len255_count", got_q.size(), 251);

        // A few short random lines.
        for (int r = 0; r < 3; r++) begin
            int len;
            len = $urandom_range(TAPS, 30);
            for (int k = 0; k < TAPS; k++) line_w[k] = $urandom_range(0, 255);
            for (int i = 0; i < len; i++) line_x[i] = $urandom_range(0, 40);
            run_line(len, 1, -1);
        end

        // Abandon a line mid-RUN with reset, then run a clean line.
        for (int k = 0; k < TAPS; k++) line_w[k] = $urandom_range(0, 255);
        for (int i = 0; i < 20; i++) line_x[i] = $urandom_range(0, 255);
        for (int p = TAPS-1; p < 20; p++) exp_q.push_back(ref_y(p));
        y_mode = 1;
        d0 = done_cnt;
        start_line(20);
        load_w();
        send_x(10, -1);
        do_reset(3);
        exp_q.delete();
        repeat (20) tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_idle", o_busy, 0);
        for (int k = 0; k < TAPS; k++) line_w[k] = $urandom_range(0, 255);
        for (int i = 0; i < 12; i++) line_x[i] = $urandom_range(0, 255);
        run_line(12, 1, -1);

        y_mode = 0;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
